// File: rtl/spi_master_interface.sv
// SPI master peripheral for IO slot 10.
// Bus-side register file, 4-entry TX/RX byte FIFOs and a CPHA=0 shift engine
// with selectable CPOL. Raises a level interrupt when queued transfers drain.
module spi_master_interface #(
  parameter int          FREQ       = 27000000,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RST    = 16'd3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cs_en,
  input  logic        i_wt_en,
  input  logic        i_rd_en,
  input  logic [3:0]  i_addr_in,
  inout  wire  [31:0] io_data,
  output logic        o_sclk,
  output logic        o_mosi,
  input  logic        i_miso,
  output logic        o_ss_n,
  output logic        o_int
);

  // FREQ only documents the system clock rate for software and the bench.
  // FIFO_DEPTH must be a power of two, at least 2.
  localparam int unsigned unusedFreqHz = FREQ;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } SpiState;

  SpiState r_state;
  SpiState w_stateNext;

  // Shift engine
  logic        r_busy;
  logic [15:0] r_halfCnt;
  logic [15:0] r_divActive;
  logic [3:0]  r_edgeCnt;
  logic        r_sclkPhase;
  logic        r_mosi;
  logic [7:0]  r_txShift;
  logic [7:0]  r_rxShift;

  // Control and status
  logic        r_cpol;
  logic        r_ie;
  logic        r_cs;
  logic [15:0] r_clkDiv;
  logic        r_txOvf;
  logic        r_rxOvf;
  logic        r_done;

  // FIFOs
  logic [7:0]    r_txMem [FIFO_DEPTH];
  logic [7:0]    r_rxMem [FIFO_DEPTH];
  logic [PW-1:0] r_txWr;
  logic [PW-1:0] r_txRd;
  logic [PW-1:0] r_rxWr;
  logic [PW-1:0] r_rxRd;

  // Combinational helpers
  logic        w_wrStrobe;
  logic        w_rdStrobe;
  logic [31:0] w_busData;
  logic [31:0] w_rdData;
  logic [7:0]  w_status;
  logic        w_txEmpty;
  logic        w_txFull;
  logic        w_rxEmpty;
  logic        w_rxFull;
  logic [7:0]  w_txHead;
  logic [7:0]  w_rxHead;
  logic        w_txPushReq;
  logic        w_txPush;
  logic        w_txPop;
  logic        w_txOvfSet;
  logic        w_rxPop;
  logic        w_rxPushOk;
  logic        w_rxOvfSet;
  logic        w_byteDone;
  logic        w_sclkTick;
  logic        w_statusWr;
  logic        w_unusedBits;

  assign w_unusedBits = ^io_data[31:16];

  assign w_wrStrobe = i_cs_en & i_wt_en;
  assign w_rdStrobe = i_cs_en & i_rd_en;
  assign w_busData  = io_data;
  assign io_data    = w_rdStrobe ? w_rdData : 32'bz;

  assign w_txEmpty = (r_txWr == r_txRd);
  assign w_txFull  = (r_txWr[AW-1:0] == r_txRd[AW-1:0]) && (r_txWr[AW] != r_txRd[AW]);
  assign w_rxEmpty = (r_rxWr == r_rxRd);
  assign w_rxFull  = (r_rxWr[AW-1:0] == r_rxRd[AW-1:0]) && (r_rxWr[AW] != r_rxRd[AW]);
  assign w_txHead  = r_txMem[r_txRd[AW-1:0]];
  assign w_rxHead  = r_rxMem[r_rxRd[AW-1:0]];

  // A full FIFO still accepts a push when the opposite side pops in the same cycle.
  assign w_txPushReq = w_wrStrobe && (i_addr_in == 4'd0);
  assign w_txPush    = w_txPushReq && (!w_txFull || w_txPop);
  assign w_txOvfSet  = w_txPushReq && w_txFull && !w_txPop;
  assign w_rxPop     = w_rdStrobe && (i_addr_in == 4'd0) && !w_rxEmpty;
  assign w_rxPushOk  = w_byteDone && (!w_rxFull || w_rxPop);
  assign w_rxOvfSet  = w_byteDone && w_rxFull && !w_rxPop;
  assign w_statusWr  = w_wrStrobe && (i_addr_in == 4'd1);

  assign w_status = {r_done, r_rxOvf, r_txOvf, w_rxFull, w_rxEmpty, w_txEmpty, w_txFull, r_busy};

  // SCLK is the edge phase folded with CPOL so idle level follows CPOL directly.
  assign o_sclk = r_sclkPhase ^ r_cpol;
  assign o_mosi = r_mosi;
  assign o_ss_n = ~r_cs;
  assign o_int  = r_ie & r_done;

  // Transfer FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next state plus the pop, SCLK-edge and byte-complete strobes.
  always_comb begin
    w_stateNext = r_state;
    w_txPop     = 1'b0;
    w_sclkTick  = 1'b0;
    w_byteDone  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_txEmpty) begin
          w_txPop     = 1'b1;
          w_stateNext = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_halfCnt == r_divActive) begin
          w_sclkTick = 1'b1;
          if (r_edgeCnt == 4'd15) begin
            w_stateNext = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_byteDone  = 1'b1;
        w_stateNext = S_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  // Shift engine: loads a byte on pop, samples MISO on even edges, drives MOSI on odd ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy      <= 1'b0;
      r_halfCnt   <= '0;
      r_divActive <= DIV_RST;
      r_edgeCnt   <= '0;
      r_sclkPhase <= 1'b0;
      r_mosi      <= 1'b0;
      r_txShift   <= '0;
      r_rxShift   <= '0;
    end else begin
      if (w_txPop) begin
        r_txShift   <= {w_txHead[6:0], 1'b0};
        r_mosi      <= w_txHead[7];
        r_halfCnt   <= '0;
        r_edgeCnt   <= '0;
        r_divActive <= r_clkDiv;
        r_busy      <= 1'b1;
      end else if (r_state == S_SHIFT) begin
        if (w_sclkTick) begin
          r_halfCnt   <= '0;
          r_sclkPhase <= ~r_sclkPhase;
          r_edgeCnt   <= r_edgeCnt + 4'd1;
          if (!r_edgeCnt[0]) begin
            r_rxShift <= {r_rxShift[6:0], i_miso};
          end else begin
            r_mosi    <= r_txShift[7];
            r_txShift <= {r_txShift[6:0], 1'b0};
          end
        end else begin
          r_halfCnt <= r_halfCnt + 16'd1;
        end
      end
      if (w_byteDone && w_txEmpty) begin
        r_busy <= 1'b0;
      end
    end
  end

  // TX FIFO pointers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_txWr <= '0;
      r_txRd <= '0;
    end else begin
      if (w_txPush) begin
        r_txWr <= r_txWr + 1'b1;
      end
      if (w_txPop) begin
        r_txRd <= r_txRd + 1'b1;
      end
    end
  end

  // TX FIFO storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge i_clk) begin
    if (w_txPush) begin
      r_txMem[r_txWr[AW-1:0]] <= w_busData[7:0];
    end
  end

  // RX FIFO pointers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rxWr <= '0;
      r_rxRd <= '0;
    end else begin
      if (w_rxPushOk) begin
        r_rxWr <= r_rxWr + 1'b1;
      end
      if (w_rxPop) begin
        r_rxRd <= r_rxRd + 1'b1;
      end
    end
  end

  // RX FIFO storage.
  always_ff @(posedge i_clk) begin
    if (w_rxPushOk) begin
      r_rxMem[r_rxWr[AW-1:0]] <= r_rxShift;
    end
  end

  // CTRL and CLKDIV; CPOL is frozen while a transfer sequence is in progress.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cpol   <= 1'b0;
      r_ie     <= 1'b0;
      r_cs     <= 1'b0;
      r_clkDiv <= DIV_RST;
    end else if (w_wrStrobe) begin
      if (i_addr_in == 4'd2) begin
        if (!r_busy) begin
          r_cpol <= w_busData[0];
        end
        r_ie <= w_busData[1];
        r_cs <= w_busData[2];
      end else if (i_addr_in == 4'd3) begin
        r_clkDiv <= w_busData[15:0];
      end
    end
  end

  // Sticky flags: write-one-to-clear, a new event in the same cycle wins.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_txOvf <= 1'b0;
      r_rxOvf <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_statusWr && w_busData[5]) begin
        r_txOvf <= 1'b0;
      end
      if (w_statusWr && w_busData[6]) begin
        r_rxOvf <= 1'b0;
      end
      if (w_statusWr && w_busData[7]) begin
        r_done <= 1'b0;
      end
      if (w_txOvfSet) begin
        r_txOvf <= 1'b1;
      end
      if (w_rxOvfSet) begin
        r_rxOvf <= 1'b1;
      end
      if (w_byteDone && w_txEmpty) begin
        r_done <= 1'b1;
      end
    end
  end

  // Register read mux; unmapped addresses and an empty RX read as zero.
  always_comb begin
    w_rdData = '0;
    case (i_addr_in)
      4'd0: begin
        if (!w_rxEmpty) begin
          w_rdData = {24'd0, w_rxHead};
        end
      end
      4'd1: w_rdData = {24'd0, w_status};
      4'd2: w_rdData = {29'd0, r_cs, r_ie, r_cpol};
      4'd3: w_rdData = {16'd0, r_clkDiv};
      default: w_rdData = '0;
    endcase
  end

endmodule

// File: tb/tb_spi_master_interface.sv
// Self-checking bench for spi_master_interface.
// Expected timing comes from closed-form byte/edge formulas and expected data
// from simple queues of what was written; nothing is read back from DUT internals.
`timescale 1ns/1ps
module tb_spi_master_interface;

  localparam int          FREQ    = 27000000;
  localparam int          DEPTH   = 4;
  localparam logic [15:0] DIV_RST = 16'd3;
  localparam real         HALF_NS = 1.0e9 / FREQ / 2.0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csEn = 1'b0;
  logic        wtEn = 1'b0;
  logic        rdEn = 1'b0;
  logic [3:0]  addr = 4'd0;
  logic [31:0] busDrive = 32'd0;
  logic        busDriveEn = 1'b0;
  wire  [31:0] dataIo;
  logic        sclk;
  logic        mosi;
  logic        miso;
  logic        ssN;
  logic        intr;

  logic        misoLoop = 1'b1;
  logic [7:0]  slaveByte = 8'd0;
  logic [3:0]  leadCnt = 4'd0;
  logic        benchCpol = 1'b0;

  int          compared = 0;
  int          mismatched = 0;
  int          cycle = 0;
  int          toggles[$];
  int          intCycle = -1;
  logic [7:0]  mosiCap = 8'd0;
  int          mosiViol = 0;
  logic        prevSclk = 1'b0;
  logic        prevMosi = 1'b0;
  logic        prevInt = 1'b0;
  logic [31:0] readVal;

  assign dataIo = busDriveEn ? busDrive : 32'bz;
  assign miso   = misoLoop ? mosi : slaveByte[3'd7 - leadCnt[2:0]];

  spi_master_interface #(
    .FREQ(FREQ),
    .FIFO_DEPTH(DEPTH),
    .DIV_RST(DIV_RST)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_cs_en(csEn),
    .i_wt_en(wtEn),
    .i_rd_en(rdEn),
    .i_addr_in(addr),
    .io_data(dataIo),
    .o_sclk(sclk),
    .o_mosi(mosi),
    .i_miso(miso),
    .o_ss_n(ssN),
    .o_int(intr)
  );

  // System clock.
  always #(HALF_NS) clk = ~clk;

  // Link monitor: logs SCLK edge cycles, MOSI at leading edges and the int rise cycle.
  always @(posedge clk) begin
    cycle++;
    #1;
    if (sclk !== prevSclk) begin
      toggles.push_back(cycle);
      if (sclk !== benchCpol) begin
        mosiCap = {mosiCap[6:0], mosi};
        leadCnt = leadCnt + 4'd1;
        if (mosi !== prevMosi) mosiViol++;
      end
    end
    if (intr && !prevInt) intCycle = cycle;
    prevSclk = sclk;
    prevMosi = mosi;
    prevInt  = intr;
  end

  // Watchdog so the run always ends.
  initial begin
    repeat (50000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  // Bus write; called at a falling edge, the register updates on the next rising edge.
  task automatic applyStimulus(input logic [3:0] a, input logic [31:0] d);
    csEn = 1'b1; wtEn = 1'b1; addr = a; busDrive = d; busDriveEn = 1'b1;
    @(negedge clk);
    csEn = 1'b0; wtEn = 1'b0; busDriveEn = 1'b0;
  endtask

  // Bus read; data is combinational, any pop happens on the following rising edge.
  task automatic readRegister(input logic [3:0] a, output logic [31:0] d);
    csEn = 1'b1; rdEn = 1'b1; addr = a;
    #1;
    d = dataIo;
    @(negedge clk);
    csEn = 1'b0; rdEn = 1'b0;
  endtask

  task automatic waitForInt(input int budget);
    int n = 0;
    while (!intr && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("intWithinBudget", {31'd0, intr}, 32'd1);
  endtask

  task automatic clearMonitor();
    toggles.delete();
    intCycle = -1;
    mosiCap  = 8'd0;
    leadCnt  = 4'd0;
    mosiViol = 0;
  endtask

  function automatic int toggleAt(input int i);
    return (i < toggles.size()) ? toggles[i] : -1;
  endfunction

  // One byte end to end, timing predicted from CLKDIV: pop one cycle after the
  // write, 16 half-periods of CLKDIV+1 cycles, one DONE cycle, then int.
  task automatic runByte(input int d, input logic cpol, input logic loop,
                         input logic [7:0] slave, input logic [7:0] txByte);
    int t0;
    logic [7:0] expRx;
    applyStimulus(4'd3, d);
    applyStimulus(4'd2, {29'd0, 1'b1, 1'b1, cpol});
    benchCpol = cpol;
    checkOutput("sclkIdle", {31'd0, sclk}, {31'd0, cpol});
    checkOutput("ssAsserted", {31'd0, ssN}, 32'd0);
    misoLoop  = loop;
    slaveByte = slave;
    clearMonitor();
    applyStimulus(4'd0, {24'd0, txByte});
    t0 = cycle;
    waitForInt(16 * (d + 1) + 10);
    expRx = loop ? txByte : slave;
    checkOutput("firstEdge", toggleAt(0), t0 + 1 + (d + 1));
    checkOutput("halfPeriod", toggleAt(1) - toggleAt(0), d + 1);
    checkOutput("lastEdge", toggleAt(15), t0 + 1 + 16 * (d + 1));
    checkOutput("edgeCount", toggles.size(), 16);
    checkOutput("intCycle", intCycle, t0 + 2 + 16 * (d + 1));
    checkOutput("mosiBits", {24'd0, mosiCap}, {24'd0, txByte});
    checkOutput("mosiStableAtLead", mosiViol, 0);
    checkOutput("sclkBackIdle", {31'd0, sclk}, {31'd0, cpol});
    readRegister(4'd1, readVal);
    checkOutput("statusAfterByte", readVal, 32'h84);
    readRegister(4'd0, readVal);
    checkOutput("rxData", readVal, {24'd0, expRx});
    readRegister(4'd1, readVal);
    checkOutput("statusRxDrained", readVal, 32'h8C);
    applyStimulus(4'd1, 32'h80);
    checkOutput("intCleared", {31'd0, intr}, 32'd0);
    misoLoop = 1'b1;
  endtask

  initial begin
    logic [7:0] burst[6];
    logic [7:0] acceptedQ[$];
    logic [7:0] rxExpQ[$];
    int d;
    int t0;
    int per;
    int nAfter;
    int n;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rstSclk", {31'd0, sclk}, 32'd0);
    checkOutput("rstMosi", {31'd0, mosi}, 32'd0);
    checkOutput("rstSsN", {31'd0, ssN}, 32'd1);
    checkOutput("rstInt", {31'd0, intr}, 32'd0);
    checkOutput("rstBusZ", {31'd0, (dataIo === 32'bz)}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    readRegister(4'd1, readVal);
    checkOutput("rstStatus", readVal, 32'h0C);
    readRegister(4'd2, readVal);
    checkOutput("rstCtrl", readVal, 32'h0);
    readRegister(4'd3, readVal);
    checkOutput("rstClkDiv", readVal, {16'd0, DIV_RST});
    readRegister(4'd7, readVal);
    checkOutput("unmappedRead", readVal, 32'h0);
    readRegister(4'd0, readVal);
    checkOutput("emptyRxRead", readVal, 32'h0);

    // Loopback bytes: the fixed 0xA5 case, then random CLKDIV/CPOL/data.
    $display("[TB] loopback single bytes");
    runByte(0, 1'b0, 1'b1, 8'h00, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      runByte($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b1, 8'h00, 8'($urandom));
    end

    // CPOL=1, CLKDIV=2, external slave returning 0x3C.
    $display("[TB] external slave, CPOL=1");
    runByte(2, 1'b1, 1'b0, 8'h3C, 8'($urandom));

    // Burst of six writes with no RX reads: one in flight plus DEPTH queued.
    $display("[TB] burst and overflow");
    d = $urandom_range(0, 2);
    per = 16 * (d + 1) + 2;
    applyStimulus(4'd3, d);
    applyStimulus(4'd2, 32'h6);
    benchCpol = 1'b0;
    misoLoop = 1'b1;
    clearMonitor();
    acceptedQ.delete();
    rxExpQ.delete();
    t0 = 0;
    for (int i = 0; i < 6; i++) begin
      burst[i] = 8'($urandom);
      if (acceptedQ.size() < DEPTH + 1) acceptedQ.push_back(burst[i]);
      applyStimulus(4'd0, {24'd0, burst[i]});
      if (i == 0) t0 = cycle;
    end
    foreach (acceptedQ[i]) if (rxExpQ.size() < DEPTH) rxExpQ.push_back(acceptedQ[i]);
    readRegister(4'd1, readVal);
    checkOutput("burstStatus", readVal, 32'h2B);
    applyStimulus(4'd2, 32'h7);
    readRegister(4'd2, readVal);
    checkOutput("cpolLockedWhileBusy", readVal, 32'h6);
    checkOutput("noIntMidBurst", {31'd0, intr}, 32'd0);
    waitForInt(acceptedQ.size() * per + 20);
    checkOutput("burstIntCycle", intCycle, t0 + 1 + (acceptedQ.size() - 1) * per + 16 * (d + 1) + 1);
    checkOutput("burstEdges", toggles.size(), 16 * acceptedQ.size());
    checkOutput("burstGap", toggleAt(16) - toggleAt(15), d + 3);
    checkOutput("burstLastStart", toggleAt(64), t0 + 1 + 4 * per + (d + 1));
    readRegister(4'd1, readVal);
    checkOutput("burstEndStatus", readVal, 32'hF4);
    applyStimulus(4'd1, 32'h80);
    checkOutput("burstIntCleared", {31'd0, intr}, 32'd0);
    foreach (rxExpQ[i]) begin
      readRegister(4'd0, readVal);
      checkOutput("rxOrder", readVal, {24'd0, rxExpQ[i]});
    end
    readRegister(4'd1, readVal);
    checkOutput("rxDrainedStatus", readVal, 32'h6C);
    readRegister(4'd0, readVal);
    checkOutput("rxEmptyRead", readVal, 32'h0);
    applyStimulus(4'd1, 32'h60);
    readRegister(4'd1, readVal);
    checkOutput("ovfCleared", readVal, 32'h0C);

    // Reset during bit 3 of a queued transfer.
    $display("[TB] reset mid-transfer");
    applyStimulus(4'd3, 32'd1);
    applyStimulus(4'd2, 32'h4);
    clearMonitor();
    for (int i = 0; i < 3; i++) applyStimulus(4'd0, 32'($urandom_range(0, 255)));
    n = 0;
    while (toggles.size() < 6 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reachedBit3", {31'd0, (toggles.size() >= 6)}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("abortSclk", {31'd0, sclk}, 32'd0);
    checkOutput("abortSsN", {31'd0, ssN}, 32'd1);
    checkOutput("abortMosi", {31'd0, mosi}, 32'd0);
    checkOutput("abortInt", {31'd0, intr}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    readRegister(4'd1, readVal);
    checkOutput("abortStatus", readVal, 32'h0C);
    readRegister(4'd3, readVal);
    checkOutput("abortClkDiv", readVal, {16'd0, DIV_RST});
    nAfter = toggles.size();
    repeat (80) @(negedge clk);
    checkOutput("noShiftAfterReset", toggles.size(), nAfter);
    readRegister(4'd0, readVal);
    checkOutput("abortRxEmpty", readVal, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
